hub75_scan_ctrl: RTL and testbench

Scan/timing controller for the HUB75 panel datapath. It sequences column shift requests, latch strobes, row select and output-enable timing for binary-code-modulated (BCM) bit planes. The datapath turns each column request into a framebuffer read and a panel clock pulse. The next plane is shifted while the current plane is displayed. The block sits between the frame store and the panel pins: the datapath consumes o_shift_*, and o_latch, o_blank and o_row_sel drive STB, OE and A..D.

---
 rtl/hub75_pkg.sv | 42 ++++
 rtl/hub75_bcm_timer.sv | 40 ++++
 rtl/hub75_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
package hub75_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StDrain,
        StWait,
        StLatch
    } scan_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rows_f(input int unsigned vpixel);
        return vpixel / 2;
    endfunction

    function automatic int unsigned col_w(input int unsigned hpixel);
        return cnt_w(hpixel);
    endfunction

    function automatic int unsigned row_w(input int unsigned vpixel);
        return cnt_w(vpixel / 2);
    endfunction

    function automatic int unsigned plane_w(input int unsigned bpp);
        return cnt_w(bpp);
    endfunction

    // Wide enough to hold the longest plane's display time.
    function automatic int unsigned timer_w(input int unsigned base_cyc, input int unsigned bpp);
        return $clog2(base_cyc << (bpp - 1)) + 1;
    endfunction

    function automatic int unsigned drain_w(input int unsigned pipe_lat);
        return cnt_w(pipe_lat);
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter that times how long a BCM plane stays lit.
module hub75_bcm_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [Width-1:0] count_q, count_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // last_o: the count reads zero on the next cycle (or already does).
    always_comb begin
        zero_o = (count_q == '0);
        last_o = (count_q <= Width'(1));
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shifts the next bit plane while the current one is
// displayed, then latches it during a one-cycle blank and starts its timer.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned HPIXEL   = 64,
    parameter int unsigned VPIXEL   = 64,
    parameter int unsigned BPP      = 8,
    parameter int unsigned BASE_CYC = 16,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_enable,
    output logic                         o_shift_valid,
    output logic [col_w(HPIXEL)-1:0]     o_shift_col,
    output logic [row_w(VPIXEL)-1:0]     o_shift_row,
    output logic [plane_w(BPP)-1:0]      o_shift_plane,
    output logic                         o_latch,
    output logic                         o_blank,
    output logic [row_w(VPIXEL)-1:0]     o_row_sel,
    output logic                         o_frame_start
);

    localparam int unsigned ROWS    = rows_f(VPIXEL);
    localparam int unsigned COL_W   = col_w(HPIXEL);
    localparam int unsigned ROW_W   = row_w(VPIXEL);
    localparam int unsigned PLANE_W = plane_w(BPP);
    localparam int unsigned TIMER_W = timer_w(BASE_CYC, BPP);
    localparam int unsigned DRAIN_W = drain_w(PIPE_LAT);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(HPIXEL - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BPP - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [TIMER_W-1:0] BASE_VAL   = TIMER_W'(BASE_CYC);

    scan_state_t        state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [ROW_W-1:0]   row_sel_q, row_sel_d;
    logic               stop_q, stop_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_zero;
    logic               tmr_last;
    logic               frame_wrap;

    hub75_bcm_timer #(
        .Width (TIMER_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero),
        .last_o     (tmr_last)
    );

    always_comb begin
        tmr_load_val = BASE_VAL << plane_q;
        frame_wrap   = (plane_q == PLANE_LAST) && (row_q == ROW_LAST);
    end

    // Next-state and counter sequencing; plane innermost, then row.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        plane_d   = plane_q;
        drain_d   = drain_q;
        row_sel_d = row_sel_q;
        stop_d    = stop_q;
        tmr_load  = 1'b0;

        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (i_enable) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (PIPE_LAT > 0) begin
                        state_d = StDrain;
                    end else begin
                        state_d = tmr_last ? StLatch : StWait;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = tmr_last ? StLatch : StWait;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            StWait: begin
                // Looking one cycle ahead lets LATCH land on the first dark cycle.
                if (tmr_last) begin
                    state_d = stop_q ? StIdle : StLatch;
                end
            end
            StLatch: begin
                tmr_load = 1'b1;
                if (plane_q == PLANE_LAST) begin
                    plane_d = '0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    plane_d = plane_q + PLANE_W'(1);
                end
                // Stopping at the frame boundary still lets the last plane finish.
                if (frame_wrap && !i_enable) begin
                    stop_d  = 1'b1;
                    state_d = StWait;
                end else begin
                    state_d = StShift;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Row address only moves as LATCH is entered, i.e. while blanked.
        if (state_d == StLatch) begin
            row_sel_d = row_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            drain_q   <= '0;
            row_sel_q <= '0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            drain_q   <= drain_d;
            row_sel_q <= row_sel_d;
            stop_q    <= stop_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        o_shift_valid = (state_q == StShift);
        o_shift_col   = col_q;
        o_shift_row   = row_q;
        o_shift_plane = plane_q;
        o_latch       = (state_q == StLatch);
        o_blank       = tmr_zero || (state_q == StLatch) || (state_q == StIdle);
        o_row_sel     = row_sel_q;
        o_frame_start = (state_q == StShift) && (col_q == '0) && (row_q == '0) &&
                        (plane_q == '0);
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: an 8x4, 2-plane panel with a shift-bound
// instance (BASE_CYC=4) and a display-bound instance (BASE_CYC=16).
module tb_hub75_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en_a, en_b;
    logic       a_valid, a_latch, a_blank, a_fs, a_row, a_plane, a_row_sel;
    logic [2:0] a_col;
    logic       b_valid, b_latch, b_blank, b_fs, b_row, b_plane, b_row_sel;
    logic [2:0] b_col;

    int errors = 0;
    int checks = 0;

    hub75_scan_ctrl #(
        .HPIXEL   (8),
        .VPIXEL   (4),
        .BPP      (2),
        .BASE_CYC (4),
        .PIPE_LAT (2)
    ) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (en_a),
        .o_shift_valid (a_valid),
        .o_shift_col   (a_col),
        .o_shift_row   (a_row),
        .o_shift_plane (a_plane),
        .o_latch       (a_latch),
        .o_blank       (a_blank),
        .o_row_sel     (a_row_sel),
        .o_frame_start (a_fs)
    );

    hub75_scan_ctrl #(
        .HPIXEL   (8),
        .VPIXEL   (4),
        .BPP      (2),
        .BASE_CYC (16),
        .PIPE_LAT (2)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (en_b),
        .o_shift_valid (b_valid),
        .o_shift_col   (b_col),
        .o_shift_row   (b_row),
        .o_shift_plane (b_plane),
        .o_latch       (b_latch),
        .o_blank       (b_blank),
        .o_row_sel     (b_row_sel),
        .o_frame_start (b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_valid, exp_latch, exp_fs, exp_blank, exp_rs, j, jl;
        logic prev_rs;

        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) tick();
        chk("rst_blank",  32'(a_blank), 1);
        chk("rst_latch",  32'(a_latch), 0);
        chk("rst_valid",  32'(a_valid), 0);
        chk("rst_fs",     32'(a_fs), 0);
        chk("rst_rowsel", 32'(a_row_sel), 0);
        chk("rst_col",    32'(a_col), 0);
        chk("rst_b_blank", 32'(b_blank), 1);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_blank", 32'(a_blank), 1);
            chk("idle_latch", 32'(a_latch), 0);
            chk("idle_valid", 32'(a_valid), 0);
        end

        // Shift-bound: every plane takes 8 shift + 2 drain + 1 latch = 11 cycles.
        // Enable drops during row 1 plane 0 of the second frame; the frame ends
        // with the latch at k=87 and its 8-cycle display, then the block idles.
        en_a    = 1'b1;
        prev_rs = a_row_sel;
        for (int k = 0; k <= 120; k++) begin
            tick();
            if (k == 70) en_a = 1'b0;
            exp_valid = int'((k < 88) && (k % 11 < 8));
            exp_latch = int'((k < 88) && (k % 11 == 10));
            exp_fs    = int'((k < 88) && (k % 44 == 0));
            exp_blank = 1;
            if (k >= 11) begin
                j = (k - 11) / 11;
                if (j <= 7 && (k - (11 * j + 10)) <= (4 << (j % 2))) exp_blank = 0;
            end
            exp_rs = 0;
            if (k >= 10) begin
                jl = (k - 10) / 11;
                if (jl > 7) jl = 7;
                exp_rs = (jl / 2) % 2;
            end
            chk("a_valid",  32'(a_valid), exp_valid);
            chk("a_latch",  32'(a_latch), exp_latch);
            chk("a_fs",     32'(a_fs), exp_fs);
            chk("a_blank",  32'(a_blank), exp_blank);
            chk("a_rowsel", 32'(a_row_sel), exp_rs);
            if (exp_valid != 0) begin
                j = k / 11;
                chk("a_col",   32'(a_col), k % 11);
                chk("a_plane", 32'(a_plane), j % 2);
                chk("a_row",   32'(a_row), (j / 2) % 2);
            end
            if (a_row_sel !== prev_rs) chk("a_rowsel_blanked", 32'(a_blank), 1);
            prev_rs = a_row_sel;
        end

        // Reset lands in the middle of a shift.
        en_a = 1'b1;
        tick();
        chk("rs_first_fs",  32'(a_fs), 1);
        chk("rs_first_col", 32'(a_col), 0);
        repeat (5) tick();
        chk("rs_col5", 32'(a_col), 5);
        rst_n = 1'b0;
        tick();
        chk("rs_valid",  32'(a_valid), 0);
        chk("rs_latch",  32'(a_latch), 0);
        chk("rs_blank",  32'(a_blank), 1);
        chk("rs_fs",     32'(a_fs), 0);
        chk("rs_rowsel", 32'(a_row_sel), 0);
        chk("rs_col",    32'(a_col), 0);
        chk("rs_row",    32'(a_row), 0);
        chk("rs_plane",  32'(a_plane), 0);
        rst_n = 1'b1;
        tick();
        chk("rs_restart_valid", 32'(a_valid), 1);
        chk("rs_restart_col",   32'(a_col), 0);
        chk("rs_restart_fs",    32'(a_fs), 1);
        chk("rs_restart_row",   32'(a_row), 0);
        chk("rs_restart_plane", 32'(a_plane), 0);
        en_a = 1'b0;

        // Display-bound: latches at 10, 27 (=10+17) and 60 (=27+33).
        en_b = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            exp_latch = int'(k == 10 || k == 27 || k == 60);
            exp_blank = int'(!((k >= 11 && k <= 26) || (k >= 28 && k <= 59)));
            exp_valid = int'(k <= 7 || (k >= 11 && k <= 18) || (k >= 28 && k <= 35));
            chk("b_latch", 32'(b_latch), exp_latch);
            chk("b_blank", 32'(b_blank), exp_blank);
            chk("b_valid", 32'(b_valid), exp_valid);
            chk("b_fs",    32'(b_fs), int'(k == 0));
            if (k == 11) begin
                chk("b_p1_col",   32'(b_col), 0);
                chk("b_p1_plane", 32'(b_plane), 1);
                chk("b_p1_row",   32'(b_row), 0);
            end
            if (k == 27) chk("b_rowsel_27", 32'(b_row_sel), 0);
            if (k == 60) chk("b_rowsel_60", 32'(b_row_sel), 1);
        end
        en_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
